// File: rtl/decode_inst_queue_if.sv
// Handshake bundle between decoder, instruction queue and scheduler.
// The master modport is the decoder/scheduler side. The slave modport is the queue.
interface decode_inst_queue_if #(
  parameter int WIDTH      = 4,
  parameter int DATA_WIDTH = 128
);
  logic                        flush_i;
  logic [WIDTH-1:0]            in_valid_i;
  logic [WIDTH*DATA_WIDTH-1:0] in_data_i;
  logic                        in_ready_o;
  logic [WIDTH-1:0]            out_valid_o;
  logic [WIDTH*DATA_WIDTH-1:0] out_data_o;
  logic                        out_ready_i;

  modport master (
    output flush_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/decode_inst_queue.sv
// decode_inst_queue: multi-lane instruction FIFO between the decoder and the scheduler.
// Accepts a whole decode group (valid lanes compacted in lane order) when at least
// WIDTH entries are free. It presents up to WIDTH oldest entries per cycle, and pops all
// presented lanes when the scheduler is ready.
// Optional feature: define INST_QUEUE_STALL_CNT_EN to add the stall_cnt_o input-stall counter.
module decode_inst_queue #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  a_rst_n,
  decode_inst_queue_if.slave    bus
`ifdef INST_QUEUE_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic                  in_ready;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      push_cnt;
  logic [CNT_W-1:0]      pop_cnt;
  logic [CNT_W-1:0]      acc;
  logic [PTR_W-1:0]      lane_off [WIDTH];

  // Free space is judged from the registered count only, so out_ready_i has no path to in_ready_o.
  assign in_ready = (count <= CNT_W'(DEPTH - WIDTH));
  assign push     = in_ready & (|bus.in_valid_i) & ~bus.flush_i;
  assign pop      = bus.out_ready_i & (count != '0) & ~bus.flush_i;
  assign pop_cnt  = (count >= CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;

  assign bus.in_ready_o = in_ready;

  // Compact valid lanes: each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_off[i] = acc[PTR_W-1:0];
      acc         = acc + CNT_W'(bus.in_valid_i[i]);
    end
    push_cnt = acc;
  end

  // Pointer and occupancy bookkeeping. Flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + push_cnt[PTR_W-1:0];
      if (pop)  head <= head + pop_cnt[PTR_W-1:0];
      count <= count + (push ? push_cnt : '0) - (pop ? pop_cnt : '0);
    end
  end

  // Payload storage is not reset; only entries covered by count are ever presented.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (push && bus.in_valid_i[i]) begin
        mem[tail + lane_off[i]] <= bus.in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Request group: the oldest min(count, WIDTH) entries as a thermometer from lane 0.
  always_comb begin
    bus.out_valid_o = '0;
    bus.out_data_o  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bus.out_valid_o[i]                          = (count > CNT_W'(i));
      bus.out_data_o[i*DATA_WIDTH +: DATA_WIDTH] = mem[head + PTR_W'(i)];
    end
  end

`ifdef INST_QUEUE_STALL_CNT_EN
  // Count cycles in which the decoder offers data but is held off. The counter saturates, and only reset clears it.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      stall_cnt_o <= '0;
    end else if ((|bus.in_valid_i) && !in_ready && !bus.flush_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_inst_queue.sv
// Self-checking bench for decode_inst_queue (WIDTH=4, DEPTH=16, DATA_WIDTH=128).
// The reference is an ideal FIFO queue plus the queue's acceptance and stall rules.
module tb_decode_inst_queue;
  localparam int W  = 4;
  localparam int D  = 16;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic a_rst_n = 1'b0;

  decode_inst_queue_if #(.WIDTH(W), .DATA_WIDTH(DW)) bus();

`ifdef INST_QUEUE_STALL_CNT_EN
  logic [31:0] stall_cnt;
  decode_inst_queue #(.WIDTH(W), .DEPTH(D), .DATA_WIDTH(DW)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .bus(bus), .stall_cnt_o(stall_cnt));
`else
  decode_inst_queue #(.WIDTH(W), .DEPTH(D), .DATA_WIDTH(DW)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  logic [31:0]   m_stall = '0;
  logic [DW-1:0] lanes [W];

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // The ideal queue advances on each clock edge, using the inputs the DUT sampled on that edge.
  task automatic model_step();
    bit ready;
    int n;
    if (!a_rst_n) begin
      q.delete();
      m_stall = '0;
    end else if (bus.flush_i) begin
      q.delete();
    end else begin
      ready = (D - q.size()) >= W;
      if (bus.out_ready_i && q.size() > 0) begin
        n = (q.size() < W) ? q.size() : W;
        repeat (n) void'(q.pop_front());
      end
      if (ready && (|bus.in_valid_i)) begin
        for (int i = 0; i < W; i++)
          if (bus.in_valid_i[i]) q.push_back(bus.in_data_i[i*DW +: DW]);
      end
      if ((|bus.in_valid_i) && !ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic drive(input logic [W-1:0] v, input logic rdy, input logic fl);
    bus.in_valid_i  = v;
    bus.out_ready_i = rdy;
    bus.flush_i     = fl;
    for (int i = 0; i < W; i++) begin
      lanes[i] = rand_word();
      bus.in_data_i[i*DW +: DW] = lanes[i];
    end
  endtask

  // On every cycle, compare the DUT against the ideal queue.
  always @(negedge clk) begin
    logic [W-1:0] ev;
    for (int i = 0; i < W; i++) ev[i] = (q.size() > i);
    check("in_ready", DW'(bus.in_ready_o), DW'((D - q.size()) >= W));
    check("out_valid", DW'(bus.out_valid_o), DW'(ev));
    for (int i = 0; i < W; i++)
      if (ev[i]) check($sformatf("out_data[%0d]", i), bus.out_data_o[i*DW +: DW], q[i]);
`ifdef INST_QUEUE_STALL_CNT_EN
    check("stall_cnt", DW'(stall_cnt), DW'(m_stall));
`endif
  end

  initial begin
    logic [DW-1:0] a0, a3, x, y, n0;
    logic [31:0]   s_before;

    drive('0, 1'b0, 1'b0);
    a_rst_n = 1'b0;
    repeat (2) tick();
    a_rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst_in_ready", DW'(bus.in_ready_o), DW'(1));
    check("rst_out_valid", DW'(bus.out_valid_o), DW'(0));

    // Four-lane push while the scheduler is stalled
    drive(4'b1111, 1'b0, 1'b0);
    a0 = lanes[0]; a3 = lanes[3];
    tick();
    drive('0, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("a_out_valid", DW'(bus.out_valid_o), DW'(4'b1111));
    check("a_lane0", bus.out_data_o[0 +: DW], a0);
    check("a_lane3", bus.out_data_o[3*DW +: DW], a3);
    check("a_count", DW'(q.size()), DW'(4));

    // Sparse valids are compacted
    drive('0, 1'b0, 1'b1); tick();
    drive(4'b0101, 1'b0, 1'b0);
    x = lanes[0]; y = lanes[2];
    tick();
    drive('0, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("b_out_valid", DW'(bus.out_valid_o), DW'(4'b0011));
    check("b_lane0", bus.out_data_o[0 +: DW], x);
    check("b_lane1", bus.out_data_o[DW +: DW], y);

    // Fill to full, then hold two stall cycles, then pop one group
    drive('0, 1'b0, 1'b1); tick();
    repeat (4) begin drive(4'b1111, 1'b0, 1'b0); tick(); end
    drive('0, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("c_full_ready", DW'(bus.in_ready_o), DW'(0));
    check("c_full_count", DW'(q.size()), DW'(16));
    drive(4'b1111, 1'b0, 1'b0); tick(); tick();
    drive('0, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("c_model_stall", DW'(m_stall), DW'(2));
    drive('0, 1'b1, 1'b0); tick();
    drive('0, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("c_pop_ready", DW'(bus.in_ready_o), DW'(1));
    check("c_pop_count", DW'(q.size()), DW'(12));

    // count=3, then push 4 and pop in the same cycle
    drive('0, 1'b0, 1'b1); tick();
    drive(4'b0111, 1'b0, 1'b0); tick();
    drive(4'b1111, 1'b1, 1'b0);
    n0 = lanes[0];
    tick();
    drive('0, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("d_out_valid", DW'(bus.out_valid_o), DW'(4'b1111));
    check("d_lane0", bus.out_data_o[0 +: DW], n0);
    check("d_count", DW'(q.size()), DW'(4));

    // Flush with count=9 and a simultaneous push
    drive('0, 1'b0, 1'b1); tick();
    drive(4'b1111, 1'b0, 1'b0); tick(); tick();
    drive(4'b0001, 1'b0, 1'b0); tick();
    drive('0, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("e_count9", DW'(q.size()), DW'(9));
    s_before = m_stall;
    drive(4'b1111, 1'b0, 1'b1); tick();
    drive('0, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("e_flush_valid", DW'(bus.out_valid_o), DW'(0));
    check("e_flush_ready", DW'(bus.in_ready_o), DW'(1));
    check("e_stall_kept", DW'(m_stall), DW'(s_before));

    // Random traffic: a filling phase, then a draining phase, with pointers wrapping
    for (int c = 0; c < 80; c++) begin
      drive(4'($urandom_range(0, 15)),
            (c < 40) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 39) == 0));
      tick();
    end

    // Asynchronous reset mid-operation
    drive(4'b1111, 1'b0, 1'b0); tick();
    drive('0, 1'b0, 1'b0);
    a_rst_n = 1'b0;
    q.delete();
    m_stall = '0;
    @(negedge clk); #1;
    check("g_rst_valid", DW'(bus.out_valid_o), DW'(0));
    check("g_rst_ready", DW'(bus.in_ready_o), DW'(1));
    tick();
    a_rst_n = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
